channel_error_injector: RTL and testbench

Models the corrupting channel between the rate-1/2 convolutional encoder and the Viterbi decoder. It registers each 2-bit encoded symbol and flips bits according to a seeded pseudo-random schedule. Corruption can be single-bit, double-bit, or bursts across consecutive symbols. It also keeps symbol and bad-bit statistics, so decoder BER runs are reproducible and self-checking.

---
 rtl/channel_error_injector.sv | 114 +++++++++++
 tb/tb_channel_error_injector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_error_injector.sv
// Corrupting channel between the rate-1/2 encoder and the Viterbi decoder.
// Registers each 2-bit symbol, flips bits on a seeded LFSR schedule and keeps statistics.
module channel_error_injector #(
  parameter int          N     = 3,
  parameter logic [31:0] SEED  = 32'hACE1_1234,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [1:0]       d_in,
  input  logic             inject_en,
  input  logic [1:0]       mode,
  input  logic [1:0]       burst_len,
  input  logic             stats_clr,
  output logic             valid_o,
  output logic [1:0]       d_out,
  output logic             err_o,
  output logic [CNT_W-1:0] sym_ct,
  output logic [CNT_W-1:0] bad_bit_ct
);

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  // An all-zero trigger mask makes every symbol a trigger (N=0).
  localparam logic [31:0] TRIG_MASK = (N <= 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - N));

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] MODE_BIT1  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [1:0]       rem;
  logic [1:0]       rem_next;
  logic [1:0]       rem_load;
  logic             trig;
  logic [1:0]       mask;
  logic [CNT_W-1:0] sym_next;
  logic [CNT_W:0]   bad_sum;
  logic [CNT_W-1:0] bad_next;

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
  assign trig      = ((lfsr & TRIG_MASK) == TRIG_MASK);
  assign rem_load  = (burst_len == 2'd0) ? 2'd0 : burst_len - 2'd1;

  // Leaving burst mode (or disabling injection) aborts any burst in progress.
  always_comb begin
    mask       = 2'b00;
    state_next = IDLE;
    rem_next   = 2'd0;
    if (inject_en) begin
      case (mode)
        MODE_BIT1: mask = trig ? 2'b10 : 2'b00;
        MODE_BOTH: mask = trig ? 2'b11 : 2'b00;
        MODE_BURST: begin
          if (state == BURST) begin
            mask       = 2'b11;
            rem_next   = rem - 2'd1;
            state_next = (rem == 2'd1) ? IDLE : BURST;
          end else if (trig) begin
            mask       = 2'b11;
            rem_next   = rem_load;
            state_next = (rem_load != 2'd0) ? BURST : IDLE;
          end
        end
        default: mask = 2'b00;
      endcase
    end
  end

  assign sym_next = (&sym_ct) ? sym_ct : sym_ct + {{(CNT_W-1){1'b0}}, 1'b1};
  assign bad_sum  = {1'b0, bad_bit_ct} + (CNT_W+1)'(mask[1]) + (CNT_W+1)'(mask[0]);
  assign bad_next = bad_sum[CNT_W] ? {CNT_W{1'b1}} : bad_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      d_out   <= 2'b00;
      err_o   <= 1'b0;
      lfsr    <= SEED_EFF;
      state   <= IDLE;
      rem     <= 2'd0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out <= d_in ^ mask;
        err_o <= |mask;
        lfsr  <= lfsr_next;
        state <= state_next;
        rem   <= rem_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct     <= '0;
      bad_bit_ct <= '0;
    end else if (stats_clr) begin
      sym_ct     <= '0;
      bad_bit_ct <= '0;
    end else if (enable_i) begin
      sym_ct     <= sym_next;
      bad_bit_ct <= bad_next;
    end
  end

endmodule

// File: tb/tb_channel_error_injector.sv
// Directed bench for channel_error_injector: three instances (default, N=0, N=0 with 4-bit counters)
// share one stimulus stream; an LFSR/burst reference model checks the default instance.
module tb_channel_error_injector;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic [1:0]  d_in;
  logic        inject_en;
  logic [1:0]  mode;
  logic [1:0]  burst_len;
  logic        stats_clr;

  logic        a_valid, b_valid, c_valid;
  logic [1:0]  a_d, b_d, c_d;
  logic        a_err, b_err, c_err;
  logic [15:0] a_sym, a_bad, b_sym, b_bad;
  logic [3:0]  c_sym, c_bad;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_lfsr;
  int          m_left;
  int          m_sym;
  int          m_bad;
  logic [1:0]  e_d;
  logic        e_err;
  logic        record;
  logic        replay;
  logic [2:0]  exp_q[$];
  logic [1:0]  stim_d[100];
  logic        stim_en[100];

  channel_error_injector dut_a (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .inject_en(inject_en),
    .mode(mode), .burst_len(burst_len), .stats_clr(stats_clr),
    .valid_o(a_valid), .d_out(a_d), .err_o(a_err), .sym_ct(a_sym), .bad_bit_ct(a_bad)
  );

  channel_error_injector #(.N(0)) dut_b (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .inject_en(inject_en),
    .mode(mode), .burst_len(burst_len), .stats_clr(stats_clr),
    .valid_o(b_valid), .d_out(b_d), .err_o(b_err), .sym_ct(b_sym), .bad_bit_ct(b_bad)
  );

  channel_error_injector #(.N(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .inject_en(inject_en),
    .mode(mode), .burst_len(burst_len), .stats_clr(stats_clr),
    .valid_o(c_valid), .d_out(c_d), .err_o(c_err), .sym_ct(c_sym), .bad_bit_ct(c_bad)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    m_lfsr = 32'hACE1_1234;
    m_left = 0;
    m_sym  = 0;
    m_bad  = 0;
    e_d    = 2'b00;
    e_err  = 1'b0;
  endtask

  task automatic model_sym(input logic en, input logic [1:0] d);
    logic       trig;
    logic [1:0] mask;
    int         blen;
    if (en) begin
      trig = (m_lfsr[2:0] == 3'b111);
      mask = 2'b00;
      blen = (burst_len == 2'd0) ? 1 : int'(burst_len);
      if (!inject_en || mode != 2'b11) m_left = 0;
      if (inject_en) begin
        if (mode == 2'b01 && trig) mask = 2'b10;
        else if (mode == 2'b10 && trig) mask = 2'b11;
        else if (mode == 2'b11) begin
          if (m_left > 0) begin
            mask = 2'b11;
            m_left--;
          end else if (trig) begin
            mask = 2'b11;
            m_left = blen - 1;
          end
        end
      end
      m_lfsr = lfsr_adv(m_lfsr);
      e_d    = d ^ mask;
      e_err  = (mask != 2'b00);
      m_sym++;
      m_bad += int'(mask[1]) + int'(mask[0]);
    end
  endtask

  // driver for the default instance, checked against the model every cycle
  task automatic drive_a(input logic en, input logic [1:0] d);
    logic [2:0] exp;
    enable_i = en;
    d_in     = d;
    model_sym(en, d);
    step();
    chk("a_valid", 32'(a_valid), 32'(en));
    chk("a_dout", 32'(a_d), 32'(e_d));
    chk("a_err", 32'(a_err), 32'(e_err));
    if (record && en) exp_q.push_back({e_err, e_d});
    if (replay && en && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("replay_trace", 32'({a_err, a_d}), 32'(exp));
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    enable_i  = 1'b0;
    d_in      = 2'b00;
    inject_en = 1'b0;
    mode      = 2'b00;
    burst_len = 2'd0;
    stats_clr = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    record = 1'b0;
    replay = 1'b0;
    rst    = 1'b0;
    do_reset();

    // reset values
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_dout", 32'(a_d), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_sym", 32'(a_sym), 32'd0);
    chk("rst_bad", 32'(a_bad), 32'd0);
    chk("rst_c_sym", 32'(c_sym), 32'd0);

    // injection disabled: transparent 1-cycle delay
    for (int i = 0; i < 256; i++) drive_a(1'b1, 2'($urandom_range(0, 3)));
    chk("t1_sym", 32'(a_sym), 32'd256);
    chk("t1_bad", 32'(a_bad), 32'd0);

    // N=0: every symbol triggers
    do_reset();
    inject_en = 1'b1;
    mode      = 2'b01;
    enable_i  = 1'b1;
    d_in      = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_bit1_dout", 32'(b_d), 32'b10);
      chk("t2_bit1_err", 32'(b_err), 32'd1);
    end
    chk("t2_bad4", 32'(b_bad), 32'd4);
    mode = 2'b10;
    d_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_both_dout", 32'(b_d), 32'b00);
      chk("t2_both_err", 32'(b_err), 32'd1);
    end
    chk("t2_bad10", 32'(b_bad), 32'd10);
    chk("t2_sym7", 32'(b_sym), 32'd7);
    enable_i = 1'b0;
    d_in     = 2'b01;
    step();
    chk("t2_idle_valid", 32'(b_valid), 32'd0);
    chk("t2_idle_hold_d", 32'(b_d), 32'b00);
    chk("t2_idle_hold_err", 32'(b_err), 32'd1);
    chk("t2_idle_sym", 32'(b_sym), 32'd7);

    // bursts against the model, enable toggled
    do_reset();
    inject_en = 1'b1;
    mode      = 2'b11;
    burst_len = 2'd3;
    for (int i = 0; i < 200; i++) drive_a((i % 2) == 0, 2'($urandom_range(0, 3)));
    burst_len = 2'd0;
    for (int i = 0; i < 40; i++) drive_a(1'b1, 2'($urandom_range(0, 3)));
    mode = 2'b01;
    for (int i = 0; i < 20; i++) drive_a(1'b1, 2'($urandom_range(0, 3)));
    mode = 2'b10;
    for (int i = 0; i < 20; i++) drive_a(1'b1, 2'($urandom_range(0, 3)));
    chk("t3_sym", 32'(a_sym), 32'(m_sym));
    chk("t3_bad", 32'(a_bad), 32'(m_bad));

    // reset mid-burst, then replay from SEED
    for (int i = 0; i < 100; i++) begin
      stim_d[i]  = 2'($urandom_range(0, 3));
      stim_en[i] = (i % 5) != 4;
    end
    do_reset();
    inject_en = 1'b1;
    mode      = 2'b11;
    burst_len = 2'd3;
    record    = 1'b1;
    for (int i = 0; i < 100; i++) drive_a(stim_en[i], stim_d[i]);
    record = 1'b0;
    begin
      int guard;
      guard = 0;
      do begin
        drive_a(1'b1, 2'($urandom_range(0, 3)));
        guard++;
      end while (m_left != 2 && guard < 300);
      chk("t4_found_burst", 32'(m_left), 32'd2);
    end
    #3 rst = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(a_valid), 32'd0);
    chk("t4_rst_dout", 32'(a_d), 32'd0);
    chk("t4_rst_err", 32'(a_err), 32'd0);
    chk("t4_rst_sym", 32'(a_sym), 32'd0);
    chk("t4_rst_bad", 32'(a_bad), 32'd0);
    step();
    rst = 1'b1;
    model_reset();
    replay = 1'b1;
    for (int i = 0; i < 100; i++) drive_a(stim_en[i], stim_d[i]);
    replay = 1'b0;

    // stats_clr beats a same-cycle increment
    do_reset();
    inject_en = 1'b1;
    mode      = 2'b10;
    enable_i  = 1'b1;
    d_in      = 2'b01;
    step();
    step();
    chk("t5_pre_bad", 32'(b_bad), 32'd4);
    stats_clr = 1'b1;
    step();
    chk("t5_clr_sym", 32'(b_sym), 32'd0);
    chk("t5_clr_bad", 32'(b_bad), 32'd0);
    chk("t5_clr_dout", 32'(b_d), 32'b10);
    stats_clr = 1'b0;
    step();
    chk("t5_post_bad", 32'(b_bad), 32'd2);
    chk("t5_post_sym", 32'(b_sym), 32'd1);

    // 4-bit counters saturate
    do_reset();
    inject_en = 1'b1;
    mode      = 2'b10;
    enable_i  = 1'b1;
    d_in      = 2'b10;
    for (int i = 0; i < 7; i++) step();
    chk("t6_sym7", 32'(c_sym), 32'd7);
    chk("t6_bad14", 32'(c_bad), 32'd14);
    step();
    chk("t6_sym8", 32'(c_sym), 32'd8);
    chk("t6_bad_sat", 32'(c_bad), 32'd15);
    for (int i = 0; i < 12; i++) step();
    chk("t6_sym_sat", 32'(c_sym), 32'd15);
    chk("t6_bad_hold", 32'(c_bad), 32'd15);
    chk("t6_b_sym", 32'(b_sym), 32'd20);
    chk("t6_b_bad", 32'(b_bad), 32'd40);
    chk("t6_c_dout", 32'(c_d), 32'b01);
    enable_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
